// File: rtl/uart_rx_display_pkg.sv
// Shared definitions for the UART receive display: read FSM states and segment codes.
// No logic of its own; purely constants and types.
// Used by both the top level and the hex segment decoder.
package uart_disp_defs;

  // Read handshake phases: wait for data, pop, capture, let the FIFO settle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    GAP  = 2'd3
  } rd_state_t;

  // All seven segments off (active low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns for hex digits; element n is the pattern for digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/uart_rx_display_seg_hex_decode.sv
// Nibble to active-low 7-segment pattern, with a blank override.
// Latency: combinational.
// No flow control.
module seg_hex_decode
  import uart_disp_defs::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins over the table lookup
  always_comb begin
    seg = blank ? SEG_BLANK : HEX_SEG[nibble];
  end

endmodule

// File: rtl/uart_rx_display.sv
// Drains bytes from uart_ctrl and shows the last two as four hex digits on a muxed display.
// Latency: byte visible on the outputs two cycles after its capture; SEG/AN lag the scan index by one cycle.
// Backpressure: pops at most one byte per four cycles, only after DATARDY is seen high in IDLE.
module uart_rx_display
  import uart_disp_defs::*;
#(
  parameter int REFRESH_DIV = 50000
)(
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATARDY,
  input  logic [7:0] RDDATA,
  input  logic       CLEAR,
  output logic       READ,
  output logic [7:0] SEG,
  output logic [3:0] AN
);

  localparam int PW = $clog2(REFRESH_DIV);

  rd_state_t      state;
  rd_state_t      state_nxt;
  logic [15:0]    buffer;
  logic [1:0]     cnt;
  logic           dp_tog;
  logic [PW-1:0]  prescaler;
  logic [1:0]     digit_idx;
  logic [3:0]     nibble;
  logic           blank;
  logic           dp_n;
  logic [6:0]     seg_dec;

  // Read FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Read FSM sequencing: one fixed four-cycle pass per byte
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (DATARDY) state_nxt = REQ;
      REQ:     state_nxt = CAP;
      CAP:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pop request is a pure decode of the REQ state
  always_comb begin
    READ = (state == REQ);
  end

  // Byte history: CLEAR drops everything, including a byte arriving in CAP
  always_ff @(posedge CLK) begin
    if (RST || CLEAR) begin
      buffer <= 16'h0;
      cnt    <= 2'd0;
      dp_tog <= 1'b0;
    end else if (state == CAP) begin
      buffer <= {buffer[7:0], RDDATA};
      cnt    <= (cnt == 2'd2) ? 2'd2 : cnt + 2'd1;
      dp_tog <= ~dp_tog;
    end
  end

  // Refresh prescaler; each wrap advances the scanned digit
  always_ff @(posedge CLK) begin
    if (RST) begin
      prescaler <= '0;
      digit_idx <= 2'd0;
    end else if (prescaler == PW'(REFRESH_DIV - 1)) begin
      prescaler <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Digit mux: pick the nibble, blanking rule and decimal point for the scanned digit
  always_comb begin
    case (digit_idx)
      2'd0:    nibble = buffer[3:0];
      2'd1:    nibble = buffer[7:4];
      2'd2:    nibble = buffer[11:8];
      default: nibble = buffer[15:12];
    endcase
    blank = digit_idx[1] ? (cnt < 2'd2) : (cnt == 2'd0);
    dp_n  = (digit_idx == 2'd0) ? ~dp_tog : 1'b1;
  end

  seg_hex_decode u_dec (
    .nibble (nibble),
    .blank  (blank),
    .seg    (seg_dec)
  );

  // Registered display drive
  always_ff @(posedge CLK) begin
    if (RST) begin
      SEG <= 8'hFF;
      AN  <= 4'b1111;
    end else begin
      SEG <= {dp_n, seg_dec};
      AN  <= ~(4'b0001 << digit_idx);
    end
  end

endmodule

// File: tb/tb_uart_rx_display.sv
// Bench for uart_rx_display with a queue-based stand-in for uart_ctrl.
// Reference: byte history, scan position from elapsed cycles, pop spacing rule.
// Directed scenarios followed by a randomized run.
module tb_uart_rx_display;

  localparam int D = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       DATARDY;
  logic [7:0] RDDATA;
  logic       CLEAR;
  logic       READ;
  logic [7:0] SEG;
  logic [3:0] AN;

  uart_rx_display #(.REFRESH_DIV(D)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DATARDY (DATARDY),
    .RDDATA  (RDDATA),
    .CLEAR   (CLEAR),
    .READ    (READ),
    .SEG     (SEG),
    .AN      (AN)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] fifo [$];

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] an_walk [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Reference state
  bit         exp_valid   = 0;
  logic       exp_read    = 1'b0;
  logic [1:0] rd_hist     = 2'b00;   // [0]=read one cycle ago, [1]=two cycles ago
  bit         cap_pending = 0;
  logic [7:0] popped      = 8'h00;
  int         n_bytes     = 0;
  bit         tog         = 0;
  logic [7:0] last0       = 8'h00;
  logic [7:0] last1       = 8'h00;
  int         k           = 0;
  logic [7:0] exp_seg     = 8'hFF;
  logic [3:0] exp_an      = 4'hF;
  logic       saw_read    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare mid-cycle, act as the FIFO, apply inputs, advance the reference
  task automatic tick(input bit rst_i, input bit clr_i);
    logic [1:0]  idx;
    logic [15:0] val;
    logic [3:0]  nib;
    bit          blank;
    logic        nxt_read;
    @(negedge CLK);
    saw_read = READ;
    if (exp_valid) begin
      check("read", {31'd0, READ}, {31'd0, exp_read});
      check("seg",  {24'd0, SEG},  {24'd0, exp_seg});
      check("an",   {28'd0, AN},   {28'd0, exp_an});
    end
    if (READ === 1'b1 && fifo.size() > 0) begin
      popped = fifo.pop_front();
      RDDATA = popped;
    end
    DATARDY = (fifo.size() != 0);
    RST     = rst_i;
    CLEAR   = clr_i;
    if (rst_i) begin
      exp_seg = 8'hFF; exp_an = 4'hF; k = 0;
      n_bytes = 0; tog = 0; last0 = 8'h00; last1 = 8'h00;
      rd_hist = 2'b00; exp_read = 1'b0; cap_pending = 0; exp_valid = 1;
    end else begin
      idx     = 2'((k / D) % 4);
      val     = {last1, last0};
      nib     = 4'(val >> (4 * idx));
      blank   = (idx >= 2) ? (n_bytes < 2) : (n_bytes < 1);
      exp_seg = {(idx == 2'd0) ? ~tog : 1'b1, blank ? 7'h7F : hex_tab[nib]};
      exp_an  = ~(4'b0001 << idx);
      k++;
      if (clr_i) begin
        n_bytes = 0; tog = 0; last0 = 8'h00; last1 = 8'h00;
      end else if (cap_pending) begin
        last1 = last0; last0 = popped; n_bytes++; tog = ~tog;
      end
      cap_pending = exp_read;
      nxt_read    = DATARDY && !exp_read && (rd_hist == 2'b00);
      rd_hist     = {rd_hist[0], exp_read};
      exp_read    = nxt_read;
    end
  endtask

  task automatic do_reset();
    repeat (3) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic settle();
    repeat (12) tick(1'b0, 1'b0);
  endtask

  // Scan all four digits twice and pin each digit's segments to literal values
  task automatic scan_pin(input string nm, input logic [7:0] s3, input logic [7:0] s2,
                          input logic [7:0] s1, input logic [7:0] s0);
    logic [7:0] want;
    for (int i = 0; i < 8 * D; i++) begin
      tick(1'b0, 1'b0);
      case (AN)
        4'b1110: want = s0;
        4'b1101: want = s1;
        4'b1011: want = s2;
        default: want = s3;
      endcase
      check(nm, {24'd0, SEG}, {24'd0, want});
    end
  endtask

  // Advance until the reference says the next cycle carries READ
  task automatic run_to_req();
    for (int i = 0; i < 20 && !exp_read; i++) tick(1'b0, 1'b0);
    if (!exp_read) begin
      vectors++;
      miscompares++;
      $display("FAIL req_timeout: got no READ within 20 cycles, want one");
    end
  endtask

  initial begin
    int reads;
    RST = 1'b1; DATARDY = 1'b0; CLEAR = 1'b0; RDDATA = 8'h00;

    // 1. reset and blank scan
    do_reset();
    check("rst_an",  {28'd0, AN},  32'hF);
    check("rst_seg", {24'd0, SEG}, 32'hFF);
    check("rst_read", {31'd0, READ}, 32'd0);
    for (int j = 0; j < 16; j++) begin
      tick(1'b0, 1'b0);
      check("an_walk",   {28'd0, AN},  {28'd0, an_walk[j / 4]});
      check("blank_seg", {24'd0, SEG}, 32'hFF);
    end

    // 2. single byte
    do_reset();
    fifo.push_back(8'hA5);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("a5_read", {31'd0, saw_read}, 32'd1);
    for (int j = 0; j < 3; j++) begin
      tick(1'b0, 1'b0);
      check("a5_noread", {31'd0, saw_read}, 32'd0);
    end
    settle();
    scan_pin("a5_disp", 8'hFF, 8'hFF, 8'h88, 8'h12);

    // 3. two bytes back to back
    do_reset();
    fifo.push_back(8'h31);
    fifo.push_back(8'hC0);
    tick(1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      tick(1'b0, 1'b0);
      check("b2b_read", {31'd0, saw_read}, (j == 0 || j == 4) ? 32'd1 : 32'd0);
    end
    settle();
    scan_pin("b2b_disp", 8'hB0, 8'hF9, 8'hC6, 8'hC0);

    // 4. third byte, count saturates, no spurious reads
    fifo.push_back(8'h7E);
    reads = 0;
    for (int j = 0; j < 20; j++) begin
      tick(1'b0, 1'b0);
      if (saw_read === 1'b1) reads++;
    end
    check("sat_reads", reads, 32'd1);
    scan_pin("sat_disp", 8'hC6, 8'hC0, 8'hF8, 8'h06);

    // 5. CLEAR in the capture cycle
    do_reset();
    fifo.push_back(8'h55);
    run_to_req();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    settle();
    scan_pin("clr_disp", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    fifo.push_back(8'h12);
    settle();
    scan_pin("clr_next", 8'hFF, 8'hFF, 8'hF9, 8'h24);

    // 6. reset during the pop request
    do_reset();
    fifo.push_back(8'h33);
    run_to_req();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("mid_rst_read", {31'd0, READ}, 32'd0);
    check("mid_rst_seg",  {24'd0, SEG},  32'hFF);
    check("mid_rst_an",   {28'd0, AN},   32'hF);
    fifo.push_back(8'h9C);
    settle();
    scan_pin("mid_rst_disp", 8'hFF, 8'hFF, 8'h90, 8'h46);

    // 7. randomized traffic with occasional CLEAR and RST
    for (int c = 0; c < 3000; c++) begin
      bit r;
      bit cl;
      if ($urandom_range(0, 5) == 0 && fifo.size() < 8) fifo.push_back(8'($urandom));
      cl = ($urandom_range(0, 49) == 0);
      r  = ($urandom_range(0, 299) == 0);
      tick(r, cl);
    end
    repeat (30) tick(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
